// File: rtl/grant_index_decoder.sv
// Grant index decoder: accepts a binary winner index over valid/ready,
// drives a registered one-hot grant until the holder releases it or the
// hold timer expires, then inserts one dead cycle before the next grant.
module grant_index_decoder #(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = 3,
    parameter int unsigned TMAX = 16,
    parameter int unsigned CW   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         idx_valid,
    input  logic [W-1:0] idx,
    output logic         idx_ready,
    input  logic [N-1:0] done,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         timeout,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(TMAX - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_q, timeout_d;
    logic           err_q, err_d;

    logic           idx_in_range;
    logic           holder_done;

    // Index legality and release by the current holder only.
    assign idx_in_range = (32'(idx) < N);
    assign holder_done  = |(done & grant_q);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: accept, hold/release/expire, single-cycle gap.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (idx_valid) begin
                    if (idx_in_range) begin
                        grant_d = N'(1) << idx;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (holder_done) begin
                    // Release wins over a simultaneous expiry.
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == CNT_LAST) begin
                    grant_d   = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Status decoded from the state register only.
    assign idx_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign grant     = grant_q;
    assign timeout   = timeout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_grant_index_decoder.sv
// Bench for grant_index_decoder: an N=8 and an N=6 instance share stimulus
// and are compared every cycle against a holder/age reference model.
module tb_grant_index_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       idx_valid;
    logic [2:0] idx;
    logic [7:0] done;

    logic [7:0] g8;
    logic       r8, b8, t8, e8;
    logic [5:0] g6;
    logic       r6, b6, t6, e6;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: who holds the grant, for how long, gap pending.
    int nn     [2] = '{8, 6};
    int holder [2] = '{-1, -1};
    int age    [2] = '{0, 0};
    bit gap    [2] = '{1'b0, 1'b0};
    bit mto    [2] = '{1'b0, 1'b0};
    bit merr   [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    grant_index_decoder #(.N(8), .W(3), .TMAX(16), .CW(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .idx_valid(idx_valid), .idx(idx),
        .idx_ready(r8), .done(done), .grant(g8), .busy(b8),
        .timeout(t8), .err(e8)
    );

    grant_index_decoder #(.N(6), .W(3), .TMAX(16), .CW(5)) dut6 (
        .clk(clk), .rst_n(rst_n), .idx_valid(idx_valid), .idx(idx),
        .idx_ready(r6), .done(done[5:0]), .grant(g6), .busy(b6),
        .timeout(t6), .err(e6)
    );

    // Expected {grant[7:0], ready, busy, timeout, err} for model k.
    function automatic logic [11:0] exp_vec(input int k);
        logic [7:0] g;
        logic       rdy;
        g   = (holder[k] >= 0) ? (8'(1) << holder[k]) : 8'h00;
        rdy = (holder[k] < 0) && !gap[k];
        return {g, rdy, !rdy, mto[k], merr[k]};
    endfunction

    // Advance one clock edge: update models with inputs seen at the edge.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            mto[k]  = 1'b0;
            merr[k] = 1'b0;
            if (!rst_n) begin
                holder[k] = -1; age[k] = 0; gap[k] = 1'b0;
            end else if (gap[k]) begin
                gap[k] = 1'b0;
            end else if (holder[k] < 0) begin
                if (idx_valid) begin
                    if (int'(idx) < nn[k]) begin holder[k] = int'(idx); age[k] = 0; end
                    else merr[k] = 1'b1;
                end
            end else if (done[holder[k]]) begin
                holder[k] = -1; gap[k] = 1'b1;
            end else if (age[k] == 15) begin
                holder[k] = -1; gap[k] = 1'b1; mto[k] = 1'b1;
            end else begin
                age[k]++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idx_valid = 1'b0; idx = 3'd0; done = 8'h00;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({g8, r8, b8, t8, e8} !== exp_vec(0)) begin
                n_fail++; $display("FAIL reset n8 cyc=%0d got=%h exp=%h", cyc, {g8, r8, b8, t8, e8}, exp_vec(0));
            end
            n_cmp++;
            if ({2'b00, g6, r6, b6, t6, e6} !== exp_vec(1)) begin
                n_fail++; $display("FAIL reset n6 cyc=%0d got=%h exp=%h", cyc, {2'b00, g6, r6, b6, t6, e6}, exp_vec(1));
            end
        end
        n_cmp++;
        if ({g8, r8, b8, t8, e8} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_idle got=%h exp=%h", {g8, r8, b8, t8, e8}, {8'h00, 4'b1000});
        end
    endtask

    task automatic test_basic();
        logic [7:0] dseq [6] = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            idx_valid = (i == 0); idx = 3'd5; done = dseq[i];
            step();
            n_cmp++;
            if ({g8, r8, b8, t8, e8} !== exp_vec(0)) begin
                n_fail++; $display("FAIL basic n8 cyc=%0d got=%h exp=%h", cyc, {g8, r8, b8, t8, e8}, exp_vec(0));
            end
            n_cmp++;
            if ({2'b00, g6, r6, b6, t6, e6} !== exp_vec(1)) begin
                n_fail++; $display("FAIL basic n6 cyc=%0d got=%h exp=%h", cyc, {2'b00, g6, r6, b6, t6, e6}, exp_vec(1));
            end
            if (i == 1) begin
                n_cmp++;
                if (g8 !== 8'b0010_0000) begin
                    n_fail++; $display("FAIL basic_grant got=%b exp=%b", g8, 8'b0010_0000);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int gcnt = 0;
        int tcnt = 0;
        idx_valid = 1'b1; idx = 3'd2; done = 8'h00;
        step();
        idx_valid = 1'b0; done = 8'hFB;
        if (g8 === 8'h04) gcnt++;
        for (int i = 0; i < 20; i++) begin
            step();
            if (g8 === 8'h04) gcnt++;
            if (t8 === 1'b1) tcnt++;
            n_cmp++;
            if ({g8, r8, b8, t8, e8} !== exp_vec(0)) begin
                n_fail++; $display("FAIL timeout n8 cyc=%0d got=%h exp=%h", cyc, {g8, r8, b8, t8, e8}, exp_vec(0));
            end
            n_cmp++;
            if ({2'b00, g6, r6, b6, t6, e6} !== exp_vec(1)) begin
                n_fail++; $display("FAIL timeout n6 cyc=%0d got=%h exp=%h", cyc, {2'b00, g6, r6, b6, t6, e6}, exp_vec(1));
            end
        end
        done = 8'h00;
        n_cmp++;
        if (gcnt != 16 || tcnt != 1) begin
            n_fail++; $display("FAIL timeout_len grant_cycles=%0d pulses=%0d exp 16/1", gcnt, tcnt);
        end
    endtask

    task automatic test_tie();
        idx_valid = 1'b1; idx = 3'd2; done = 8'h00;
        step();
        idx_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            done = (i == 15) ? 8'h04 : 8'h00;
            step();
            n_cmp++;
            if ({g8, r8, b8, t8, e8} !== exp_vec(0)) begin
                n_fail++; $display("FAIL tie n8 cyc=%0d got=%h exp=%h", cyc, {g8, r8, b8, t8, e8}, exp_vec(0));
            end
            n_cmp++;
            if ({2'b00, g6, r6, b6, t6, e6} !== exp_vec(1)) begin
                n_fail++; $display("FAIL tie n6 cyc=%0d got=%h exp=%h", cyc, {2'b00, g6, r6, b6, t6, e6}, exp_vec(1));
            end
            if (i == 15) begin
                n_cmp++;
                if ({g8, t8} !== 9'h000) begin
                    n_fail++; $display("FAIL tie_done_wins grant=%b timeout=%b exp 0/0", g8, t8);
                end
            end
        end
        done = 8'h00;
    endtask

    task automatic test_range();
        for (int i = 0; i < 6; i++) begin
            idx_valid = (i < 2); idx = (i == 0) ? 3'd7 : 3'd0;
            done = (i >= 3) ? 8'hFF : 8'h00;
            step();
            n_cmp++;
            if ({g8, r8, b8, t8, e8} !== exp_vec(0)) begin
                n_fail++; $display("FAIL range n8 cyc=%0d got=%h exp=%h", cyc, {g8, r8, b8, t8, e8}, exp_vec(0));
            end
            n_cmp++;
            if ({2'b00, g6, r6, b6, t6, e6} !== exp_vec(1)) begin
                n_fail++; $display("FAIL range n6 cyc=%0d got=%h exp=%h", cyc, {2'b00, g6, r6, b6, t6, e6}, exp_vec(1));
            end
            if (i == 0) begin
                n_cmp++;
                if ({e6, g6, r6} !== {1'b1, 6'b000000, 1'b1}) begin
                    n_fail++; $display("FAIL range_err err=%b grant=%b ready=%b exp 1/000000/1", e6, g6, r6);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if ({e6, g6} !== {1'b0, 6'b000001}) begin
                    n_fail++; $display("FAIL range_next err=%b grant=%b exp 0/000001", e6, g6);
                end
            end
        end
        idx_valid = 1'b0; done = 8'h00;
    endtask

    task automatic test_back_to_back();
        int first  = -1;
        int second = -1;
        logic [11:0] ev;
        idx_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            idx  = (first < 0) ? 3'd1 : 3'd3;
            ev   = exp_vec(0);
            done = ev[11:4];
            step();
            if (first < 0 && g8 === 8'h02) first = cyc;
            if (second < 0 && g8 === 8'h08) second = cyc;
            n_cmp++;
            if ({g8, r8, b8, t8, e8} !== exp_vec(0)) begin
                n_fail++; $display("FAIL b2b n8 cyc=%0d got=%h exp=%h", cyc, {g8, r8, b8, t8, e8}, exp_vec(0));
            end
            n_cmp++;
            if ({2'b00, g6, r6, b6, t6, e6} !== exp_vec(1)) begin
                n_fail++; $display("FAIL b2b n6 cyc=%0d got=%h exp=%h", cyc, {2'b00, g6, r6, b6, t6, e6}, exp_vec(1));
            end
        end
        n_cmp++;
        if (first < 0 || second - first != 3) begin
            n_fail++; $display("FAIL b2b_spacing first=%0d second=%0d exp gap 3", first, second);
        end
        idx_valid = 1'b0; done = 8'hFF;
        step(); step(); step();
        done = 8'h00;
        // Third grant, then reset while it is held.
        idx_valid = 1'b1; idx = 3'd4;
        step();
        idx_valid = 1'b0;
        step(); step();
        rst_n = 1'b0; done = 8'h10;
        step();
        n_cmp++;
        if ({g8, r8, b8, t8, e8} !== exp_vec(0)) begin
            n_fail++; $display("FAIL midreset n8 cyc=%0d got=%h exp=%h", cyc, {g8, r8, b8, t8, e8}, exp_vec(0));
        end
        n_cmp++;
        if ({g8, b8, g6, b6} !== 16'h0000) begin
            n_fail++; $display("FAIL midreset_clear grant8=%h busy8=%b grant6=%h busy6=%b exp 0", g8, b8, g6, b6);
        end
        rst_n = 1'b1; done = 8'h00;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            idx_valid = $urandom_range(0, 1) == 1;
            idx       = 3'($urandom_range(0, 7));
            done      = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            step();
            n_cmp++;
            if ({g8, r8, b8, t8, e8} !== exp_vec(0)) begin
                n_fail++; $display("FAIL random n8 cyc=%0d got=%h exp=%h", cyc, {g8, r8, b8, t8, e8}, exp_vec(0));
            end
            n_cmp++;
            if ({2'b00, g6, r6, b6, t6, e6} !== exp_vec(1)) begin
                n_fail++; $display("FAIL random n6 cyc=%0d got=%h exp=%h", cyc, {2'b00, g6, r6, b6, t6, e6}, exp_vec(1));
            end
        end
        rst_n = 1'b1; idx_valid = 1'b0; done = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        step(); step();
        test_tie();
        test_range();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
